// File: rtl/sys_time_idx_gen.sv
// Derives the modulation/STM sample index from global time once per ultrasound period:
// IDX = ((SYS_TIME >> TIME_SHIFT) / FREQ_DIV) mod CYCLE, using a serial restoring divider.
module sys_time_idx_gen #(
  parameter int TIME_SHIFT = 8,
  parameter int TW         = 56,
  parameter int W          = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOCKED,
  input  logic [63:0]      SYS_TIME,
  input  logic [W-1:0]     FREQ_DIV,
  input  logic [W-1:0]     CYCLE,
  output logic [W-1:0]     IDX,
  output logic             IDX_UPDATE,
  output logic             VALID,
  output logic             BUSY,
  output logic [1:0]       STATE_DBG
);

  localparam int CW = $clog2(TW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_MOD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] step_cnt;
  logic [TW-1:0] shreg;      // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [W:0]    rem;
  logic [W-1:0]  div_q;
  logic [W-1:0]  cyc_q;
  logic [W-1:0]  res_q;
  logic          pend;

  logic          trigger;
  logic          illegal;
  logic          last_step;
  logic [W:0]    divisor;
  logic [W:0]    trial;
  logic          take;

  assign trigger   = (state == S_IDLE) && LOCKED && (SYS_TIME[TIME_SHIFT-1:0] == '0);
  assign illegal   = (FREQ_DIV == '0) || (CYCLE == '0);
  assign last_step = (step_cnt == CW'(TW - 1));
  assign divisor   = (state == S_MOD) ? {1'b0, cyc_q} : {1'b0, div_q};
  assign trial     = {rem[W-1:0], shreg[TW-1]};
  assign take      = (trial >= divisor);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (trigger && !illegal) state_nxt = S_DIV;
      S_DIV:  if (last_step) state_nxt = S_MOD;
      S_MOD:  if (last_step) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    BUSY      = (state != S_IDLE);
    STATE_DBG = state;
  end

  // Datapath and result registers; the result lands one edge after DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      step_cnt   <= '0;
      shreg      <= '0;
      rem        <= '0;
      div_q      <= '0;
      cyc_q      <= '0;
      res_q      <= '0;
      pend       <= 1'b0;
      IDX        <= '0;
      IDX_UPDATE <= 1'b0;
      VALID      <= 1'b0;
    end else begin
      IDX_UPDATE <= 1'b0;
      if (pend) begin
        IDX        <= res_q;
        VALID      <= 1'b1;
        IDX_UPDATE <= (res_q != IDX) || !VALID;
        pend       <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (trigger) begin
            shreg    <= SYS_TIME[63:TIME_SHIFT];
            div_q    <= FREQ_DIV;
            cyc_q    <= CYCLE;
            rem      <= '0;
            step_cnt <= '0;
            if (illegal) VALID <= 1'b0;
          end
        end
        S_DIV, S_MOD: begin
          rem      <= take ? (trial - divisor) : trial;
          shreg    <= {shreg[TW-2:0], take};
          step_cnt <= last_step ? '0 : step_cnt + 1'b1;
          // Quotient is complete in shreg; the modulo pass starts from a zero remainder.
          if ((state == S_DIV) && last_step) rem <= '0;
        end
        S_DONE: begin
          res_q <= rem[W-1:0];
          pend  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_time_idx_gen.sv
// Bench for sys_time_idx_gen: directed scenarios plus randomized time/settings,
// checked every cycle against an arithmetic model of the index rule.
module tb_sys_time_idx_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        LOCKED;
  logic [63:0] SYS_TIME;
  logic [15:0] FREQ_DIV;
  logic [15:0] CYCLE;
  logic [15:0] IDX;
  logic        IDX_UPDATE;
  logic        VALID;
  logic        BUSY;
  logic [1:0]  STATE_DBG;

  sys_time_idx_gen dut (
    .CLK(CLK), .RST(RST), .LOCKED(LOCKED), .SYS_TIME(SYS_TIME),
    .FREQ_DIV(FREQ_DIV), .CYCLE(CYCLE), .IDX(IDX), .IDX_UPDATE(IDX_UPDATE),
    .VALID(VALID), .BUSY(BUSY), .STATE_DBG(STATE_DBG)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_idx(input logic [63:0] st, input logic [15:0] fd,
                                           input logic [15:0] cy);
    logic [63:0] t;
    t = st >> 8;
    return 16'((t / 64'(fd)) % 64'(cy));
  endfunction

  longint      n = 0;
  logic [15:0] exp_idx   = '0;
  logic        exp_valid = 1'b0;
  logic        exp_upd   = 1'b0;
  logic        exp_busy  = 1'b0;
  logic        pend_on   = 1'b0;
  logic [15:0] pend_val  = '0;
  longint      pend_due  = 0;
  logic        busy_on   = 1'b0;
  longint      busy_start = 0;
  longint      trig_256_edge = -1;

  always @(posedge CLK) begin
    n = n + 1;
    if (RST) begin
      exp_idx = '0; exp_valid = 1'b0; exp_upd = 1'b0;
      pend_on = 1'b0; busy_on = 1'b0;
    end else begin
      exp_upd = 1'b0;
      if (pend_on && n == pend_due) begin
        exp_upd   = (pend_val != exp_idx) || !exp_valid;
        exp_idx   = pend_val;
        exp_valid = 1'b1;
        pend_on   = 1'b0;
      end
      // A computation occupies edges S+1 .. S+113; a new trigger is accepted from S+114.
      if (busy_on && n > busy_start + 113) busy_on = 1'b0;
      if (!busy_on && LOCKED && SYS_TIME[7:0] == 8'h00) begin
        if (FREQ_DIV == 16'h0 || CYCLE == 16'h0) begin
          exp_valid = 1'b0;
        end else begin
          pend_val   = ref_idx(SYS_TIME, FREQ_DIV, CYCLE);
          pend_due   = n + 114;
          pend_on    = 1'b1;
          busy_on    = 1'b1;
          busy_start = n;
        end
      end
      if (SYS_TIME == 64'd256) trig_256_edge = n;
    end
    exp_busy = busy_on && (n <= busy_start + 112);
  end

  // ---------------- scoreboard / compare ----------------
  logic [15:0] pulse_q[$];
  longint      pulse_edge_q[$];

  always @(negedge CLK) begin
    if (n >= 1) begin
      check("idx", IDX, exp_idx);
      check("valid", VALID, exp_valid);
      check("idx_update", IDX_UPDATE, exp_upd);
      check("busy", BUSY, exp_busy);
      if (IDX_UPDATE === 1'b1) begin
        pulse_q.push_back(IDX);
        pulse_edge_q.push_back(n);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
    SYS_TIME = SYS_TIME + 64'd1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic clear_log();
    pulse_q.delete();
    pulse_edge_q.delete();
  endtask

  task automatic check_log(input string name, input logic [15:0] exp[$]);
    check({name, "_count"}, 64'(pulse_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < pulse_q.size()) check({name, "_value"}, pulse_q[i], exp[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] e[$];
    RST = 1'b1; LOCKED = 1'b1; FREQ_DIV = 16'd1; CYCLE = 16'd4; SYS_TIME = 64'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_idx", IDX, 16'd0);
    check("rst_valid", VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_upd", IDX_UPDATE, 1'b0);

    // Basic index sequence
    RST = 1'b0; SYS_TIME = 64'd1; clear_log();
    run(1200);
    e = '{16'd1, 16'd2, 16'd3, 16'd0};
    check_log("basic", e);
    if (pulse_edge_q.size() > 0) check("basic_latency", 64'(pulse_edge_q[0] - trig_256_edge), 64'd114);
    check("basic_valid", VALID, 1'b1);

    // No-change suppression
    SYS_TIME = 64'd6 * 256 - 5; FREQ_DIV = 16'd3; CYCLE = 16'd5; clear_log();
    run(4 * 256 + 130);
    e = '{16'd2, 16'd3};
    check_log("nochange", e);

    // Illegal settings
    SYS_TIME = 64'd11 * 256 - 3; CYCLE = 16'd0; clear_log();
    run(10);
    check("illegal_valid", VALID, 1'b0);
    check("illegal_idx_hold", IDX, 16'd3);
    check("illegal_busy", BUSY, 1'b0);
    check("illegal_no_pulse", 64'(pulse_q.size()), 64'd0);
    CYCLE = 16'd4;
    run(256 + 130);
    e = '{16'd0};
    check_log("restore", e);
    check("restore_valid", VALID, 1'b1);

    // Large time with settings changed mid-flight
    SYS_TIME = 64'hFFFF_FFFF_FFFF_FF00 - 2; FREQ_DIV = 16'hFFFF; CYCLE = 16'hFFFF;
    run(5);
    FREQ_DIV = 16'd7; CYCLE = 16'd3;
    run(125);
    check("large_idx", IDX, 16'd768);
    FREQ_DIV = 16'd1; CYCLE = 16'd4;
    run(250);

    // Reset mid-computation
    SYS_TIME = 64'd5 * 256 - 2;
    run(52);
    RST = 1'b1;
    run(2);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_idx", IDX, 16'd0);
    check("midrst_valid", VALID, 1'b0);
    RST = 1'b0; clear_log();
    run(256 + 130);
    e = '{16'd2};
    check_log("after_rst", e);

    // Lock gating
    LOCKED = 1'b0; SYS_TIME = 64'd7 * 256 - 3; clear_log();
    run(10);
    check("unlocked_busy", BUSY, 1'b0);
    check("unlocked_no_pulse", 64'(pulse_q.size()), 64'd0);
    LOCKED = 1'b1; SYS_TIME = 64'd8 * 256 - 2;
    run(12);
    LOCKED = 1'b0;
    run(110);
    e = '{16'd0};
    check_log("lock_drop", e);
    LOCKED = 1'b1;

    // Randomized time, jumps, settings, lock and resets
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 60) == 0)
        FREQ_DIV = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      if ($urandom_range(0, 60) == 0)
        CYCLE = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      if ($urandom_range(0, 40) == 0) LOCKED = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 300) == 0)
        SYS_TIME = ({32'($urandom), 32'($urandom)} & ~64'hFF) - 64'($urandom_range(0, 3));
      RST = ($urandom_range(0, 1500) == 0);
      tick();
    end
    RST = 1'b0;
    run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_time_idx_gen.md
Name: sys_time_idx_gen

Overview:
- Sits directly downstream of the clock/system-time source and consumes its CLK and 64-bit SYS_TIME.
- Once per ultrasound period (256 CLK cycles), derives a sample index for the modulation/STM buffers: IDX = ((SYS_TIME >> 8) / FREQ_DIV) mod CYCLE.
- Uses a multi-cycle serial divider, so all time-synchronised devices compute the same index from the same global time.

Parameters:
- TIME_SHIFT, 8, log2 of CLK cycles per ultrasound period; the period count t = SYS_TIME[63:TIME_SHIFT].
- TW, 56, width of t (64 - TIME_SHIFT).
- W, 16, width of FREQ_DIV, CYCLE and IDX.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- LOCKED  in  1  clock-source lock; triggers are ignored while low.
- SYS_TIME  in  64  free-running global time in CLK cycles.
- FREQ_DIV  in  W  ultrasound periods per sample.
- CYCLE  in  W  number of samples in the buffer.
- IDX  out  W  current sample index.
- IDX_UPDATE  out  1  one-cycle pulse when IDX takes a new value.
- VALID  out  1  high once an index has been computed with legal settings.
- BUSY  out  1  high while a computation is in flight.

Behaviour:
- Reset: IDX=0, IDX_UPDATE=0, VALID=0, BUSY=0, state=IDLE, internal registers cleared. Reset mid-computation aborts it with no result and no pulse.
- Trigger: in IDLE, a cycle with LOCKED=1 and SYS_TIME[TIME_SHIFT-1:0]==0 latches t, FREQ_DIV and CYCLE into shadow registers. Call this trigger edge S.
- Settings are sampled only at the trigger; changes mid-computation take effect at the next trigger.
- Illegal settings: if the latched FREQ_DIV==0 or CYCLE==0, go straight to IDLE. VALID<=0, IDX holds its value, no IDX_UPDATE pulse.
- States: IDLE -> DIV -> MOD -> DONE -> IDLE.
- DIV: restoring division t / FREQ_DIV, one quotient bit per cycle, MSB first, TW cycles. The remainder register is W+1 bits; the quotient is TW bits.
- MOD: restoring division of the quotient by CYCLE, TW cycles. Only the remainder r (W bits) is kept.
- DONE: one cycle; registers the result.
- BUSY=1 in DIV, MOD and DONE.
- Triggers that arrive while BUSY are ignored. Per-result latency is TW+TW+2 = 114 edges, well under 256.
- Result timing: IDX<=r is visible after edge S+114.
- VALID<=1 at that same edge.
- IDX_UPDATE pulses for exactly one cycle, coincident with the new IDX, when either condition holds: r differs from the previous IDX, or VALID was 0 before this edge. Otherwise no pulse.
- Wrap-around: q mod CYCLE wraps naturally to 0. SYS_TIME overflow at 2^64 needs no special case.
- A SYS_TIME jump (DC resync) just yields the new index at the next trigger. A pulse follows if the index changed.
- LOCKED falling mid-computation does not abort; only RST aborts.
- Arithmetic is unsigned throughout. No rounding.

Test Plan:
- Basic index: RST then release; FREQ_DIV=1, CYCLE=4, LOCKED=1, SYS_TIME counting up from 1. Trigger at SYS_TIME=256 -> IDX=1, VALID=1, IDX_UPDATE single pulse, all 114 edges after the trigger. Next triggers give IDX=2, 3, 0, each with a pulse.
- No-change suppression: FREQ_DIV=3, CYCLE=5, SYS_TIME stepping through periods t=6,7,8 -> IDX=2 with a pulse at t=6, then no pulse at t=7 and t=8. t=9 -> IDX=3 with a pulse.
- Illegal settings: CYCLE=0 at a trigger -> VALID=0, IDX holds, no pulse, BUSY low the next cycle. Restoring CYCLE=4 -> the next trigger sets VALID=1 with a pulse.
- Large time and mid-flight settings: SYS_TIME=0xFFFF_FFFF_FFFF_FF00 at trigger, FREQ_DIV=0xFFFF, CYCLE=0xFFFF -> IDX = (0xFF_FFFF_FFFF_FFFF/0xFFFF) mod 0xFFFF, checked against a reference model. Changing FREQ_DIV during the computation does not alter this result.
- Reset mid-operation: assert RST at S+50 -> BUSY=0, IDX=0, VALID=0, no pulse. After release, the next trigger computes normally.
- Lock gating: LOCKED=0 across a trigger -> BUSY stays 0, no state change. LOCKED dropping at S+10 -> the result still completes at S+114.
